// File: rtl/compare_sequencer.sv
// Bit-serial MSB-first compare sequencer: walks a and b through an external
// bit-compare cell with a SETUP/EVAL handshake, then holds the result until acknowledged.
module compare_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             reqParent,
  output logic             req,
  output logic             xBit,
  output logic             yBit,
  input  logic             finEqual,
  input  logic             finSmaller,
  input  logic             finBigger,
  output logic             busy,
  output logic             done,
  output logic             resBigger,
  output logic             resEqual,
  output logic             resSmaller,
  output logic             err,
  input  logic             ackIn
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EVAL, S_DONE} state_t;

  state_t         state, nxt_state;
  logic [WIDTH-1:0] cap_a, cap_b, nxt_a, nxt_b;
  logic [IW-1:0]  idx, nxt_idx;
  logic [CW-1:0]  cnt, nxt_cnt;
  logic           nxt_big, nxt_eq, nxt_sm, nxt_err;
  logic           nxt_busy, nxt_req, nxt_xbit, nxt_ybit;
  logic [1:0]     fin_cnt;

  // State, captured operands and every output are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cap_a      <= '0;
      cap_b      <= '0;
      idx        <= '0;
      cnt        <= '0;
      reqParent  <= 1'b0;
      req        <= 1'b0;
      xBit       <= 1'b0;
      yBit       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      resBigger  <= 1'b0;
      resEqual   <= 1'b0;
      resSmaller <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= nxt_state;
      cap_a      <= nxt_a;
      cap_b      <= nxt_b;
      idx        <= nxt_idx;
      cnt        <= nxt_cnt;
      reqParent  <= nxt_busy;
      req        <= nxt_req;
      xBit       <= nxt_xbit;
      yBit       <= nxt_ybit;
      busy       <= nxt_busy;
      done       <= (nxt_state == S_DONE);
      resBigger  <= nxt_big;
      resEqual   <= nxt_eq;
      resSmaller <= nxt_sm;
      err        <= nxt_err;
    end
  end

  // Next-state logic; outputs are derived from the next state so they align with it.
  always_comb begin
    nxt_state = state;
    nxt_a     = cap_a;
    nxt_b     = cap_b;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    nxt_big   = resBigger;
    nxt_eq    = resEqual;
    nxt_sm    = resSmaller;
    nxt_err   = err;
    fin_cnt   = 2'(finEqual) + 2'(finSmaller) + 2'(finBigger);

    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_a     = a;
          nxt_b     = b;
          nxt_idx   = IW'(WIDTH - 1);
          nxt_state = S_SETUP;
        end
      end
      S_SETUP: begin
        nxt_cnt   = '0;
        nxt_state = S_EVAL;
      end
      S_EVAL: begin
        if (fin_cnt > 2'd1) begin
          nxt_err   = 1'b1;
          nxt_state = S_DONE;
        end else if (finBigger) begin
          nxt_big   = 1'b1;
          nxt_state = S_DONE;
        end else if (finSmaller) begin
          nxt_sm    = 1'b1;
          nxt_state = S_DONE;
        end else if (finEqual) begin
          if (idx != '0) begin
            nxt_idx   = idx - IW'(1);
            nxt_state = S_SETUP;
          end else begin
            nxt_eq    = 1'b1;
            nxt_state = S_DONE;
          end
        end else if (cnt >= CW'(TIMEOUT - 1)) begin
          // Silent cell: give up after TIMEOUT consecutive empty evaluations.
          nxt_err   = 1'b1;
          nxt_state = S_DONE;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (ackIn) begin
          nxt_big   = 1'b0;
          nxt_eq    = 1'b0;
          nxt_sm    = 1'b0;
          nxt_err   = 1'b0;
          nxt_state = S_IDLE;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    nxt_busy = (nxt_state == S_SETUP) || (nxt_state == S_EVAL);
    nxt_req  = (nxt_state == S_EVAL);
    nxt_xbit = 1'b0;
    nxt_ybit = 1'b0;
    if (nxt_busy) begin
      nxt_xbit = nxt_a[nxt_idx];
      nxt_ybit = nxt_b[nxt_idx];
    end
  end

endmodule

// File: doc/compare_sequencer.md
COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 1..32.
REQ-002 SHALL have parameter TIMEOUT, default 4: number of consecutive EVAL cycles with no fin response before an error is declared, legal range 1..255.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port start  input  1  request to compare a and b, sampled in IDLE only.
REQ-007 SHALL have port a  input  WIDTH  first operand, captured when start is accepted.
REQ-008 SHALL have port b  input  WIDTH  second operand, captured when start is accepted.
REQ-009 SHALL have port reqParent  output  1  enable to the bit-compare cell, high in SETUP and EVAL.
REQ-010 SHALL have port req  output  1  evaluation request to the bit-compare cell, high in EVAL only.
REQ-011 SHALL have ports xBit and yBit  output  1 each  current bit of captured a and b.
REQ-012 SHALL have ports finEqual, finSmaller, finBigger  input  1 each  bit-compare cell responses.
REQ-013 SHALL have port busy  output  1  high in SETUP and EVAL.
REQ-014 SHALL have port done  output  1  result valid, high in DONE.
REQ-015 SHALL have ports resBigger, resEqual, resSmaller, err  output  1 each  registered result flags, valid while done=1.
REQ-016 SHALL have port ackIn  input  1  consumer acknowledge of the result.

Function
REQ-017 SHALL implement states IDLE, SETUP, EVAL, DONE, with a bit index starting at WIDTH-1 and a timeout counter.
REQ-018 In IDLE with start=1, SHALL capture a and b, set the index to WIDTH-1, and enter SETUP; start SHALL be ignored in all other states.
REQ-019 In SETUP, xBit and yBit SHALL equal the captured bits at the index, req SHALL be 0, the timeout counter SHALL clear, and the block SHALL enter EVAL on the next edge.
REQ-020 In EVAL, req SHALL be 1, xBit and yBit SHALL be held, and the fin lines SHALL be sampled every edge.
REQ-021 In EVAL, exactly finBigger=1 SHALL set resBigger=1 and enter DONE, and exactly finSmaller=1 SHALL set resSmaller=1 and enter DONE.
REQ-022 In EVAL, exactly finEqual=1 with index>0 SHALL decrement the index and enter SETUP, giving a return-to-zero phase on req between bits.
REQ-023 In EVAL, exactly finEqual=1 with index=0 SHALL set resEqual=1 and enter DONE.
REQ-024 In EVAL, two or more fin lines high SHALL set err=1 with all res flags 0 and enter DONE.
REQ-025 In EVAL, no fin line high SHALL increment the counter; on the TIMEOUT-th consecutive such cycle the block SHALL set err=1 with all res flags 0 and enter DONE.
REQ-026 Latency: with prompt responses, done SHALL rise 2k edges after the edge accepting start, where k is the number of bits evaluated; equal operands give k=WIDTH.
REQ-027 In DONE, done and the result flags SHALL hold until ackIn=1 is sampled, and the block SHALL then return to IDLE with done and all flags cleared on that edge.
REQ-028 ackIn outside DONE SHALL be ignored.
REQ-029 In IDLE and DONE, reqParent, req, xBit and yBit SHALL be 0.
REQ-030 Exactly one of resBigger, resEqual, resSmaller, err SHALL be high whenever done=1.

Reset
REQ-031 rst=1 SHALL immediately force IDLE and set every output to 0, including reqParent, req, xBit, yBit, busy, done, all res flags and err.
REQ-032 rst=1 SHALL clear the captured operands, the index and the counter.
REQ-033 Reset asserted mid-operation SHALL abandon the comparison without producing done.
REQ-034 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-035 Bench SHALL cover: WIDTH=8, a=0xA5, b=0xA5, ideal cell model -> 8 req pulses, resEqual=1, done rises 16 edges after start.
REQ-036 Bench SHALL cover: a=0x80, b=0x7F -> a single req pulse, resBigger=1 at edge 2; a=0x12, b=0x13 -> resSmaller=1 at edge 16.
REQ-037 Bench SHALL cover: cell model silent, TIMEOUT=4 -> err=1 after 4 EVAL cycles, and done held until ackIn, then IDLE.
REQ-038 Bench SHALL cover: finEqual and finBigger both forced high -> err=1, with resBigger, resEqual and resSmaller all 0.
REQ-039 Bench SHALL cover: rst pulsed during EVAL of bit 5 -> all outputs 0 immediately, no done, and a new start after release runs from bit 7.
REQ-040 Bench SHALL cover: start held high through DONE and ackIn -> exactly one new compare begins after the return to IDLE.
